uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo_mem.sv | 29 ++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: default receive widths/depths and FIFO helpers.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Encoding matches {write accepted, pop accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_POP   = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } fifoOp_e;

  function automatic int fifoAddrWidth(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the receive FIFO.
// It has one synchronous write port and one combinational read port.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int ADDR_WIDTH = fifoAddrWidth(UART_FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // No reset: contents are only visible once written.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// This is the receive-side byte FIFO that sits between the UART receiver and the bus.
// It is first-word-fall-through, and rx_data shows the oldest held byte, or 0 when empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int AF_LEVEL   = 12
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          fifo_write,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          read_rx_byte,
  input  logic                          clear_overflow,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          receive_full,
  output logic                          fifo_full,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [fifoAddrWidth(DEPTH):0] level
);

  localparam int ADDR_WIDTH  = fifoAddrWidth(DEPTH);
  localparam int LEVEL_WIDTH = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]  wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic                   receiveFull_q, fifoFull_q, almostFull_q;
  logic                   writeReq, doPop, doWrite, dropWrite;
  fifoOp_e                op;
  logic [DATA_WIDTH-1:0]  headData;

  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  always_comb begin
    writeReq  = ~fifo_write;
    doPop     = read_rx_byte & (level_q != '0);
    doWrite   = writeReq & ((level_q != LEVEL_WIDTH'(DEPTH)) | doPop);
    dropWrite = writeReq & ~doWrite;
    op        = fifoOp_e'({doWrite, doPop});
  end

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    unique case (op)
      OP_WRITE: begin
        wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
        level_d = level_q + LEVEL_WIDTH'(1);
      end
      OP_POP: begin
        rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
        level_d = level_q - LEVEL_WIDTH'(1);
      end
      OP_BOTH: begin
        wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
        rdPtr_d = rdPtr_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
    if (dropWrite) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Flags come from the next-state level, so they match the level register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
      receiveFull_q <= 1'b0;
      fifoFull_q    <= 1'b0;
      almostFull_q  <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
      receiveFull_q <= (level_d != '0);
      fifoFull_q    <= (level_d == LEVEL_WIDTH'(DEPTH));
      almostFull_q  <= (level_d >= LEVEL_WIDTH'(AF_LEVEL));
    end
  end

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (doWrite),
    .wr_addr_i (wrPtr_q),
    .wr_data_i (wr_data),
    .rd_addr_i (rdPtr_q),
    .rd_data_o (headData)
  );

  assign rx_data      = receiveFull_q ? headData : '0;
  assign receive_full = receiveFull_q;
  assign fifo_full    = fifoFull_q;
  assign almost_full  = almostFull_q;
  assign overflow     = overflow_q;
  assign level        = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes, monitor pops on each read.
// Flags and level are compared against a small reference model of the FIFO.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       fifo_write = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       read_rx_byte = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [7:0] rx_data;
  logic       receive_full, fifo_full, almost_full, overflow;
  logic [4:0] level;

  int   checks = 0;
  int   failures = 0;
  logic [7:0] expQ[$];
  int   modelLevel = 0;
  logic modelOvf = 1'b0;
  logic [7:0] lastPopped = 8'h00;

  uart_rx_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AF_LEVEL   (12)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_write     (fifo_write),
    .wr_data        (wr_data),
    .read_rx_byte   (read_rx_byte),
    .clear_overflow (clear_overflow),
    .rx_data        (rx_data),
    .receive_full   (receive_full),
    .fifo_full      (fifo_full),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .level          (level)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (reset_n && read_rx_byte && receive_full) begin
      if (expQ.size() == 0) begin
        checkVal("pop_on_empty_model", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        checkVal("pop_data", 32'(rx_data), 32'(expQ.pop_front()));
        lastPopped = rx_data;
      end
    end
  end

  task automatic applyStimulus(input logic doWr, input logic [7:0] d, input logic doRd,
                               input logic clr);
    logic mPop, mWr;
    fifo_write     = ~doWr;
    wr_data        = d;
    read_rx_byte   = doRd;
    clear_overflow = clr;
    mPop = doRd && (modelLevel != 0);
    mWr  = doWr && ((modelLevel != 16) || mPop);
    if (mWr) expQ.push_back(d);
    if (doWr && !mWr) modelOvf = 1'b1;
    else if (clr) modelOvf = 1'b0;
    modelLevel = modelLevel + int'(mWr) - int'(mPop);
    @(posedge clk);
    #1;
    fifo_write     = 1'b1;
    read_rx_byte   = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_level"}, 32'(level), 32'(modelLevel));
    checkVal({tag, "_receive_full"}, 32'(receive_full), 32'(modelLevel != 0));
    checkVal({tag, "_fifo_full"}, 32'(fifo_full), 32'(modelLevel == 16));
    checkVal({tag, "_almost_full"}, 32'(almost_full), 32'(modelLevel >= 12));
    checkVal({tag, "_overflow"}, 32'(overflow), 32'(modelOvf));
    if (modelLevel == 0) checkVal({tag, "_rx_empty"}, 32'(rx_data), 32'h0);
    else if (expQ.size() > 0) checkVal({tag, "_rx_head"}, 32'(rx_data), 32'(expQ[0]));
  endtask

  task automatic drain();
    while (modelLevel > 0) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    #12;
    checkVal("reset_level", 32'(level), 32'h0);
    checkVal("reset_rx_data", 32'(rx_data), 32'h0);
    checkVal("reset_flags", {28'h0, receive_full, fifo_full, almost_full, overflow}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte in and out.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkVal("a5_rx_data", 32'(rx_data), 32'hA5);
    checkVal("a5_receive_full", 32'(receive_full), 32'h1);
    checkVal("a5_level", 32'(level), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("a5_pop_rx_data", 32'(rx_data), 32'h0);
    checkVal("a5_pop_receive_full", 32'(receive_full), 32'h0);

    // Pop on empty is ignored.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("empty_pop");

    // Fill, drop one write, then drain in order.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    checkVal("full_fifo_full", 32'(fifo_full), 32'h1);
    checkVal("full_overflow", 32'(overflow), 32'h1);
    checkOutput("full");
    drain();
    checkVal("full_last_pop", 32'(lastPopped), 32'h0F);
    checkOutput("full_drained");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkVal("full_ovf_cleared", 32'(overflow), 32'h0);

    // Almost-full threshold.
    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    checkVal("af_11", 32'(almost_full), 32'h0);
    applyStimulus(1'b1, 8'h2B, 1'b0, 1'b0);
    checkVal("af_12", 32'(almost_full), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("af_pop", 32'(almost_full), 32'h0);
    drain();

    // Simultaneous write and pop while full.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
    checkVal("fullrw_level", 32'(level), 32'd16);
    checkVal("fullrw_overflow", 32'(overflow), 32'h0);
    drain();
    checkVal("fullrw_last_pop", 32'(lastPopped), 32'h5A);

    // Set beats clear when both happen in the same cycle.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    checkVal("ovf_set", 32'(overflow), 32'h1);
    applyStimulus(1'b1, 8'hEF, 1'b0, 1'b1);
    checkVal("ovf_set_wins", 32'(overflow), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkVal("ovf_lone_clear", 32'(overflow), 32'h0);
    drain();

    // Empty FIFO with simultaneous write and pop accepts only the write.
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkVal("empty_rw_level", 32'(level), 32'h1);
    checkVal("empty_rw_rx_data", 32'(rx_data), 32'h77);
    drain();

    // Random traffic with pointer wrap.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                    1'($urandom_range(0, 9) == 0));
      checkOutput("rand");
      if (level > 5'd16) checkVal("rand_level_bound", 32'(level), 32'd16);
    end
    drain();
    checkOutput("rand_drained");

    // Reset in the middle of a write discards it.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    fifo_write = 1'b0;
    wr_data    = 8'h33;
    #2;
    reset_n = 1'b0;
    #1;
    checkVal("midrst_level", 32'(level), 32'h0);
    checkVal("midrst_rx_data", 32'(rx_data), 32'h0);
    checkVal("midrst_receive_full", 32'(receive_full), 32'h0);
    expQ.delete();
    modelLevel = 0;
    modelOvf   = 1'b0;
    @(posedge clk);
    #1;
    fifo_write = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset");
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    checkVal("post_reset_rx_data", 32'(rx_data), 32'h3C);
    checkVal("post_reset_level", 32'(level), 32'h1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
